unibus_arb: RTL
===============

UNIBUS_ARB -- requirements
Module: unibus_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, meaning clk cycles a grant is held awaiting SACK before cancel.
REQ-002 SHALL have parameter DESKEW, default 4, meaning idle clk cycles between arbitration decision and grant assertion.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 bus_init  input  1  UNIBUS INIT, synchronous clear.
REQ-006 bus_br  input  [7:4]  bus requests, active-high.
REQ-007 bus_npr  input  1  non-processor request.
REQ-008 bus_sack  input  1  selection acknowledge from requesting device.
REQ-009 bus_bbsy  input  1  bus busy.
REQ-010 cpu_pri  input  [2:0]  processor priority (PSW[7:5]).
REQ-011 cpu_brk  input  1  CPU at instruction boundary; BR grants permitted.
REQ-012 bus_bg_out  output  [7:4]  bus grants, at most one high.
REQ-013 bus_npg_out  output  1  NPR grant.
REQ-014 arb_busy  output  1  high in any state other than IDLE.
REQ-015 nosack  output  1  one-cycle pulse on grant timeout.

Function
REQ-016 States: IDLE, DESKEW, GRANT, SACKWAIT; encoding from shared package.
REQ-017 IDLE: NPR wins over all BRs; NPR needs neither cpu_brk nor cpu_pri.
REQ-018 IDLE: BRn eligible only if cpu_brk=1 and n > cpu_pri; highest eligible n wins.
REQ-019 IDLE with winner: latch winner, load counter with DESKEW, go DESKEW; no winner: stay IDLE.
REQ-020 Arbitration SHALL NOT start while bus_sack=1; stay IDLE.
REQ-021 DESKEW: decrement each cycle; at 0 go GRANT; latched grant asserted in the cycle GRANT is entered (registered output).
REQ-022 DESKEW=0: GRANT entered cycle after IDLE decision.
REQ-023 GRANT: grant held until bus_sack=1 or TIMEOUT cycles elapse; request withdrawal SHALL NOT drop grant.
REQ-024 GRANT, bus_sack=1: grant negated next cycle, go SACKWAIT.
REQ-025 GRANT, TIMEOUT reached, no SACK: grant negated, nosack pulsed one cycle, go IDLE.
REQ-026 SACK and timeout same cycle: SACK wins, no nosack.
REQ-027 SACKWAIT: stay while bus_sack=1; on bus_sack=0 go IDLE (bus_bbsy does not gate; next arbitration overlaps current transfer).
REQ-028 Latched winner SHALL NOT change after IDLE decision, even if higher request arrives or cpu_pri rises.
REQ-029 Counter width ceil(log2(max(TIMEOUT,DESKEW)+1)); no wrap; saturates at terminal count.
REQ-030 bus_bg_out and bus_npg_out SHALL be mutually exclusive at all times.
REQ-031 bus_init=1: next cycle IDLE, all grants 0, nosack 0, counter 0; overrides all transitions.

Reset
REQ-032 reset low: immediately IDLE; bus_bg_out=0, bus_npg_out=0, arb_busy=0, nosack=0, counter=0, latched winner cleared.
REQ-033 Reset mid-grant: grant drops asynchronously; no nosack pulse; after release arbitration restarts from IDLE.

Structure
REQ-034 Shared package SHALL hold state encoding, level constants (LVL_NPR, LVL_BR7..LVL_BR4) and default TIMEOUT/DESKEW.
REQ-035 One sub-module unibus_arb_prio: combinational priority encoder (br, npr, cpu_pri, cpu_brk -> winner, valid).

Verification
REQ-036 cpu_pri=3, cpu_brk=1, bus_br=4'b0101 (BR6, BR4) -> after DESKEW=4 cycles bus_bg_out=4'b0100; sack=1 -> grant 0 next cycle.
REQ-037 bus_npr=1, bus_br[7]=1, cpu_brk=0 -> bus_npg_out=1, bus_bg_out=0 throughout.
REQ-038 cpu_pri=6, bus_br[6]=1 -> no grant for 100 cycles; cpu_pri drops to 5 -> bus_bg_out[6]=1 after DESKEW+1 cycles.
REQ-039 BR5 granted, no SACK, TIMEOUT=16 -> grant drops after 16 cycles, nosack pulses exactly one cycle, state IDLE.
REQ-040 SACK asserted on terminal timeout cycle -> no nosack, SACKWAIT entered; hold SACK 10 cycles -> no new grant until SACK=0.
REQ-041 reset low during GRANT -> bus_bg_out=0 same cycle; bus_init during DESKEW -> IDLE next cycle, no grant.

Source files
------------

// File: rtl/unibus_arb_pkg.sv
// Shared definitions for the UNIBUS bus-grant arbiter.
//   arb_state_t : arbiter FSM state encoding
//   lvl_t       : request level of the latched winner (BR levels carry their
//                 own number so the low two bits index bus_bg_out[7:4])
//   DEF_TIMEOUT / DEF_DESKEW : default parameter values
//   ctr_width() : width of the shared deskew/timeout counter
package unibus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DESKEW   = 2'd1,
    ST_GRANT    = 2'd2,
    ST_SACKWAIT = 2'd3
  } arb_state_t;

  typedef enum logic [2:0] {
    LVL_NONE = 3'd0,
    LVL_NPR  = 3'd1,
    LVL_BR4  = 3'd4,
    LVL_BR5  = 3'd5,
    LVL_BR6  = 3'd6,
    LVL_BR7  = 3'd7
  } lvl_t;

  localparam int DEF_TIMEOUT = 1024;
  localparam int DEF_DESKEW  = 4;

  // Counter must hold the larger of the two load values; never narrower than 1 bit.
  function automatic int ctr_width(input int timeout, input int deskew);
    int m;
    m = (timeout > deskew) ? timeout : deskew;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/unibus_arb_prio.sv
// Combinational priority encoder for the UNIBUS arbiter.
//   br_i      : bus requests BR7..BR4
//   npr_i     : non-processor request (always wins, ignores CPU state)
//   cpu_pri_i : processor priority; BRn only eligible when n > cpu_pri_i
//   cpu_brk_i : CPU at an instruction boundary; BR grants only then
//   winner_o  : winning level, LVL_NONE when nothing is eligible
//   valid_o   : a winner exists
module unibus_arb_prio
  import unibus_arb_pkg::*;
(
  input  logic [7:4] br_i,
  input  logic       npr_i,
  input  logic [2:0] cpu_pri_i,
  input  logic       cpu_brk_i,
  output lvl_t       winner_o,
  output logic       valid_o
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  always_comb begin
    winner_o = LVL_NONE;
    valid_o  = 1'b0;
    if (npr_i) begin
      winner_o = LVL_NPR;
      valid_o  = 1'b1;
    end else if (cpu_brk_i) begin
      // Ascending scan: a later (higher) eligible level overrides a lower one.
      for (int n = 4; n <= 7; n++) begin
        if (br_i[n] && (3'(n) > cpu_pri_i)) begin
          winner_o = lvl_t'(3'(n));
          valid_o  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/unibus_arb.sv
// UNIBUS bus arbiter: picks NPR or the highest eligible BR, waits DESKEW idle
// cycles, then asserts a registered grant until SACK or TIMEOUT.
//   clk, reset        : clock, asynchronous active-low reset
//   bus_init          : synchronous clear, overrides every transition
//   bus_br[7:4]       : bus requests        bus_npr : non-processor request
//   bus_sack          : selection acknowledge
//   bus_bbsy          : bus busy (observed only; arbitration overlaps transfers)
//   cpu_pri, cpu_brk  : processor priority and instruction-boundary flag
//   bus_bg_out[7:4]   : one-hot BR grant    bus_npg_out : NPR grant
//   arb_busy          : FSM not in IDLE     nosack : one-cycle grant timeout pulse
module unibus_arb
  import unibus_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int DESKEW  = DEF_DESKEW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_init,
  input  logic [7:4] bus_br,
  input  logic       bus_npr,
  input  logic       bus_sack,
  input  logic       bus_bbsy,
  input  logic [2:0] cpu_pri,
  input  logic       cpu_brk,
  output logic [7:4] bus_bg_out,
  output logic       bus_npg_out,
  output logic       arb_busy,
  output logic       nosack
);

  localparam int            CW     = ctr_width(TIMEOUT, DESKEW);
  localparam logic [CW-1:0] TMO_LD = CW'(TIMEOUT);
  localparam logic [CW-1:0] DSK_LD = CW'(DESKEW);
  localparam logic [CW-1:0] ONE    = CW'(1);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] ctr_q, ctr_d;
  lvl_t          win_q, win_d;
  logic [7:4]    bg_q, bg_d;
  logic          npg_q, npg_d;
  logic          nosack_q, nosack_d;

  lvl_t prio_win;
  logic prio_valid;

  // Bus busy deliberately does not gate arbitration.
  logic bbsy_unused;
  assign bbsy_unused = bus_bbsy;

  unibus_arb_prio u_prio (
    .br_i      (bus_br),
    .npr_i     (bus_npr),
    .cpu_pri_i (cpu_pri),
    .cpu_brk_i (cpu_brk),
    .winner_o  (prio_win),
    .valid_o   (prio_valid)
  );

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    win_d    = win_q;
    nosack_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ctr_d = '0;
        win_d = LVL_NONE;
        // A device still holding SACK blocks a new decision.
        if (!bus_sack && prio_valid) begin
          win_d = prio_win;
          if (DESKEW == 0) begin
            state_d = ST_GRANT;
            ctr_d   = TMO_LD;
          end else begin
            state_d = ST_DESKEW;
            ctr_d   = DSK_LD;
          end
        end
      end
      ST_DESKEW: begin
        // Loaded with DESKEW, so exactly DESKEW cycles are spent here.
        if (ctr_q <= ONE) begin
          state_d = ST_GRANT;
          ctr_d   = TMO_LD;
        end else begin
          ctr_d = ctr_q - ONE;
        end
      end
      ST_GRANT: begin
        // SACK is tested first so it wins over a simultaneous timeout.
        if (bus_sack) begin
          state_d = ST_SACKWAIT;
          ctr_d   = '0;
        end else if (ctr_q <= ONE) begin
          state_d  = ST_IDLE;
          ctr_d    = '0;
          win_d    = LVL_NONE;
          nosack_d = 1'b1;
        end else begin
          ctr_d = ctr_q - ONE;
        end
      end
      ST_SACKWAIT: begin
        if (!bus_sack) begin
          state_d = ST_IDLE;
          win_d   = LVL_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus_init) begin
      state_d  = ST_IDLE;
      ctr_d    = '0;
      win_d    = LVL_NONE;
      nosack_d = 1'b0;
    end

    // Grants are registered: asserted on the edge that enters GRANT, held
    // there, and cleared on the edge that leaves it. Only one can be set.
    bg_d  = '0;
    npg_d = 1'b0;
    if (state_d == ST_GRANT) begin
      if (win_d == LVL_NPR) npg_d = 1'b1;
      else if (win_d[2])    bg_d  = 4'b0001 << win_d[1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ctr_q    <= '0;
      win_q    <= LVL_NONE;
      bg_q     <= '0;
      npg_q    <= 1'b0;
      nosack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      win_q    <= win_d;
      bg_q     <= bg_d;
      npg_q    <= npg_d;
      nosack_q <= nosack_d;
    end
  end

  assign bus_bg_out  = bg_q;
  assign bus_npg_out = npg_q;
  assign arb_busy    = (state_q != ST_IDLE);
  assign nosack      = nosack_q;

endmodule
